sqrt_arbiter: RTL

- Shares one `sqrt` core (ports init, A[15:0], result[15:0], done) among NUM_REQ requesters, e.g. CPU MMIO port and DMA-style engines on the femtoRV SoC.
- Grants requesters round-robin and latches the winner's operand.
- Sequences the core's init/done protocol, guards it with a watchdog, and returns the result (or an error) to the winner only.

---
 rtl/sqrt_arb_pkg.sv | 20 ++
 rtl/sqrt_arbiter_rr_pick.sv | 31 +++
 rtl/sqrt_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sqrt_arb_pkg.sv
// Shared definitions for the sqrt core arbiter: FSM encoding, default sizes and
// the modular-add helper used for round-robin indexing.
package sqrt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_TIMEOUT = 64;

  // (a + b) mod n, valid while a < n and b < n
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b >= n) ? a + b - n : a + b;
  endfunction

endpackage

// File: rtl/sqrt_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick
  import sqrt_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0]      cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // cand[gi] is the requester gi positions after ptr
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand[gi] = IW'(wrap_add(int'(ptr), gi, NUM_REQ));
    assign hit[gi]  = req[cand[gi]];
  end

  always_comb begin
    found = |hit;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one sqrt core among NUM_REQ requesters, with a
// done-edge detector and a watchdog that turns a silent core into an error reply.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] operand,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     core_init,
  output logic [WIDTH-1:0]         core_A,
  input  logic [WIDTH-1:0]         core_result,
  input  logic                     core_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t     state_reg, state_next;
  logic [IW-1:0]  winner_reg, winner_next;
  logic [IW-1:0]  ptr_reg, ptr_next;
  logic [WIDTH-1:0] core_a_reg, core_a_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic           err_reg, err_next;
  logic [TW-1:0]  timer_reg, timer_next;
  logic           done_q_reg;

  logic           pick_found;
  logic [IW-1:0]  pick_idx;
  logic [WIDTH-1:0] op_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_op
    assign op_arr[gi] = operand[gi*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      winner_reg <= '0;
      ptr_reg    <= '0;
      core_a_reg <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      timer_reg  <= '0;
      done_q_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      winner_reg <= winner_next;
      ptr_reg    <= ptr_next;
      core_a_reg <= core_a_next;
      result_reg <= result_next;
      err_reg    <= err_next;
      timer_reg  <= timer_next;
      done_q_reg <= core_done;
    end
  end

  always_comb begin
    state_next  = state_reg;
    winner_next = winner_reg;
    ptr_next    = ptr_reg;
    core_a_next = core_a_reg;
    result_next = result_reg;
    err_next    = err_reg;
    timer_next  = timer_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          winner_next = pick_idx;
          core_a_next = op_arr[pick_idx];
          state_next  = START;
        end
      end
      START: begin
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        timer_next = timer_reg + TW'(1);
        // A done edge beats a coinciding timeout; a level left over from the
        // previous op is masked by done_q until it falls and rises again.
        if (core_done && !done_q_reg) begin
          result_next = core_result;
          err_next    = 1'b0;
          state_next  = RESP;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          result_next = '0;
          err_next    = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: begin
        ptr_next   = IW'(wrap_add(int'(winner_reg), 1, NUM_REQ));
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign rsp_valid[gi] = (state_reg == RESP) && (winner_reg == IW'(gi));
  end

  assign rsp_data  = (state_reg == RESP) ? result_reg : '0;
  assign rsp_err   = (state_reg == RESP) && err_reg;
  assign busy      = (state_reg != IDLE);
  assign core_init = (state_reg == START);
  assign core_A    = core_a_reg;

endmodule
